// File: rtl/lsu_ctrl_if.sv
// Pipeline-side and data-memory-side handshake bundle for the load/store sequencer.
interface lsu_ctrl_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AWIDTH-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DWIDTH-1:0] mem_rdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  // The sequencer itself; master is the pipeline plus memory environment around it.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_wdata,
    output rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wdata,
    input  rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one access at a time, byte-lane placement and load extension.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with an error.
module lsu_ctrl #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              req_legal, req_misalign;
  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DWIDTH-1:0] ld_data, st_data;
  logic [3:0]        st_mask;

  always_comb begin
    if (bus.req_we) begin
      req_legal = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
    end else begin
      req_legal = (bus.req_funct3[1:0] != 2'b11) && (bus.req_funct3 != 3'b110);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    req_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    req_misalign = 1'b0;
`endif
  end

  // Sub-size address bits are simply dropped, so unaligned accesses fold onto their lane.
  always_comb begin
    off     = addr_q[1:0];
    ld_byte = bus.mem_rdata[{off, 3'b000} +: 8];
    ld_half = off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
    case (funct3_q[1:0])
      2'b00: begin
        st_mask = 4'b0001 << off;
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_mask = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          data_d   = '0;
          err_d    = 1'b0;
          if (!req_legal || req_misalign) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = we_q ? StResp : StWaitRsp;
        end
      end
      StWaitRsp: begin
        // Data arriving on the timeout cycle takes priority over the error.
        if (bus.mem_rsp_valid) begin
          data_d  = ld_data;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Memory-side and response outputs are forced to zero outside their owning state.
  assign bus.req_ready     = (state_q == StIdle);
  assign bus.busy          = (state_q != StIdle);
  assign bus.mem_req_valid = (state_q == StIssue);
  assign bus.mem_addr      = (state_q == StIssue) ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
  assign bus.mem_we        = (state_q == StIssue && we_q) ? st_mask : 4'b0000;
  assign bus.mem_wdata     = (state_q == StIssue && we_q) ? st_data : '0;
  assign bus.rsp_valid     = (state_q == StResp);
  assign bus.rsp_data      = (state_q == StResp) ? data_q : '0;
  assign bus.rsp_err       = (state_q == StResp) && err_q;
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sequencer between the CPU memory stage and the data-memory port. Accepts one load or store at a time, issues a word-aligned memory request with byte mask, and waits for read data. Applies RISC-V load byte/halfword selection and sign/zero extension to the read data. Returns a single-cycle response to the pipeline and holds `busy` high while the pipeline must stall.

## Interface
- `DWIDTH`, 32: data width; only 32 supported.
- `AWIDTH`, 32: byte-address width.
- `TIMEOUT`, 255: maximum cycles in WAIT_RSP before the load is aborted with an error.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  pipeline request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 of the load/store.
- `req_addr`  in  AWIDTH  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_addr`  out  AWIDTH  word address; bits [1:0] always 0.
- `mem_we`  out  4  byte write mask; 0000 for loads.
- `mem_wdata`  out  32  lane-positioned store data.
- `mem_rsp_valid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  32  extended load result; 0 for stores and errors.
- `rsp_err`  out  1  qualifies `rsp_valid`: access failed.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, `req_funct3`, `req_addr`, `req_wdata` and the byte offset `off = req_addr[1:0]`.
  - Valid request goes to ISSUE.
  - Illegal funct3 goes to RESP with error and makes no memory access.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
- ISSUE:
  - `mem_req_valid`=1. Address, mask and data are held stable until `mem_req_ready`.
  - On handshake, a store goes to RESP and a load goes to WAIT_RSP.
- WAIT_RSP:
  - On `mem_rsp_valid`, register the formatted data and go to RESP.
  - A cycle counter increments every cycle; at count `TIMEOUT`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - `mem_rsp_valid` is ignored in all other states.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- Store mask and data:
  - SB: mask = 0001<<off; data = {4{wdata[7:0]}}.
  - SH: mask = 0011<<(2*off[1]); data = {2{wdata[15:0]}}.
  - SW: mask = 1111; data = wdata.
- Load format, byte b = rdata[8*off +: 8], half h = rdata[16*off[1] +: 16]:
  - LB: sign-extend b. LBU: zero-extend b.
  - LH: sign-extend h. LHU: zero-extend h.
  - LW: rdata unchanged.

## Timing
- Reset values of all outputs are 0, except `req_ready`=1. FSM resets to IDLE and the counter to 0.
- Accepted in cycle N → `mem_req_valid` in N+1.
- Store with immediate ready → `rsp_valid` in N+2.
- Load with ready in N+1 and `mem_rsp_valid` in N+2 → `rsp_valid` in N+3.
- A back-to-back request can be accepted in the cycle after RESP.
- `mem_rsp_valid` arriving in the same cycle as the timeout count: the data wins, `rsp_err`=0.
- Reset asserted mid-transaction aborts it immediately. A memory response arriving after reset is ignored.
- `rsp_data`/`rsp_err` may be non-zero only while `rsp_valid`=1; they are 0 otherwise.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned requests go IDLE→RESP with `rsp_err`=1 and no memory access.
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- Macro undefined:
  - Low address bits below the access size are ignored; halfword uses addr[1] only, word uses offset 0.
  - The access proceeds normally.

## Test plan
- LW at 0x104, memory returns 0xabcdef12 → `mem_addr`=0x104, `mem_we`=0000, `rsp_data`=0xabcdef12, `rsp_valid` 3 cycles after accept.
- LB at 0x101 and LBU at 0x102, rdata 0xabcdef12 → LB gives 0xffffffef, LBU gives 0x000000cd. LH at 0x102 gives 0xffffabcd; LHU at 0x100 gives 0x0000ef12.
- SB at 0x203, wdata 0x000000a5, `mem_req_ready` held low 3 cycles → outputs stable; `mem_we`=1000, `mem_wdata`=0xa5a5a5a5; `rsp_data`=0.
- Load with no `mem_rsp_valid`, `TIMEOUT`=8 → `rsp_valid` with `rsp_err`=1 and `rsp_data`=0; the next request is accepted afterwards.
- funct3=011 load or funct3=100 store → no `mem_req_valid`, `rsp_err`=1. `rst_n` pulsed during WAIT_RSP → all outputs return to reset values and a late `mem_rsp_valid` gives no `rsp_valid`.
- LW at 0x102: with macro → `rsp_err`=1, no memory access. Without macro → `mem_addr`=0x100 and normal data.
